// File: rtl/sft_reg_seq.sv
// Command sequencer for an external universal shift register: accepts LOAD/shift/READ
// commands, drives the register mode and parallel input, and returns its final contents.
module sft_reg_seq #(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [W-1:0]  cmd_data,
  input  logic [CW-1:0] cmd_cnt,
  output logic [1:0]    sel,
  output logic [W-1:0]  pin,
  input  logic [W-1:0]  pout,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_data,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPT,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b11;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  pin_q, pin_d;
  logic [W-1:0]  rsp_q, rsp_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      pin_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      pin_q   <= pin_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    pin_d   = pin_q;
    rsp_d   = rsp_q;
    sel     = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          cnt_d = cmd_cnt;
          if (cmd_op == OP_LOAD) begin
            pin_d   = cmd_data;
            state_d = S_LOAD;
          end else if (cmd_op != OP_READ && cmd_cnt != '0) begin
            state_d = S_SHIFT;
          end else begin
            state_d = S_CAPT;
          end
        end
      end
      S_LOAD: begin
        sel     = 2'b11;
        state_d = S_CAPT;
      end
      S_SHIFT: begin
        // op encoding 01/10 doubles as the register's right/left mode code
        sel   = op_q;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_CAPT;
      end
      S_CAPT: begin
        rsp_d   = pout;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_q;
  assign pin       = pin_q;

endmodule

// File: tb/tb_sft_reg_seq.sv
// Directed bench for sft_reg_seq; a 4-bit universal shift register with zero fill is modelled here.
module tb_sft_reg_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_cnt;
  logic [1:0] sel;
  logic [3:0] pin;
  logic [3:0] pout;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       busy;

  int tests = 0;
  int fails = 0;

  logic [3:0] ureg = 4'b0000;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    case (sel)
      2'b01:   ureg <= {1'b0, ureg[3:1]};
      2'b10:   ureg <= {ureg[2:0], 1'b0};
      2'b11:   ureg <= pin;
      default: ureg <= ureg;
    endcase
  end
  assign pout = ureg;

  sft_reg_seq #(.W(4), .CW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_cnt   (cmd_cnt),
    .sel       (sel),
    .pin       (pin),
    .pout      (pout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents a command in the current cycle T and returns in cycle T+1.
  task automatic send(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_cnt   = cnt;
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick;
    tick;
    tests++; if (sel !== 2'b00) begin fails++; $display("FAIL reset_sel got %b exp 00", sel); end
    tests++; if (pin !== 4'b0000) begin fails++; $display("FAIL reset_pin got %b exp 0000", pin); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    rst = 1'b1;
    tick;
  endtask

  task automatic test_load;
    rsp_ready = 1'b1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL load_ready got %b exp 1", cmd_ready); end
    send(2'b11, 4'b1010, 3'd0);
    tests++; if (sel !== 2'b11) begin fails++; $display("FAIL load_sel got %b exp 11", sel); end
    tests++; if (pin !== 4'b1010) begin fails++; $display("FAIL load_pin got %b exp 1010", pin); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL load_busy got %b exp 1", busy); end
    tick;
    tests++; if (sel !== 2'b00) begin fails++; $display("FAIL load_capt_sel got %b exp 00", sel); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL load_early_valid got %b exp 0", rsp_valid); end
    tick;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL load_rsp_valid got %b exp 1", rsp_valid); end
    tests++; if (rsp_data !== 4'b1010) begin fails++; $display("FAIL load_rsp_data got %b exp 1010", rsp_data); end
    tick;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL load_idle got %b exp 1", cmd_ready); end
  endtask

  task automatic test_zero_and_read;
    send(2'b10, 4'b0000, 3'd0);
    tests++; if (sel !== 2'b00) begin fails++; $display("FAIL zero_sel got %b exp 00", sel); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL zero_early_valid got %b exp 0", rsp_valid); end
    tick;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL zero_rsp_valid got %b exp 1", rsp_valid); end
    tests++; if (rsp_data !== 4'b1010) begin fails++; $display("FAIL zero_rsp_data got %b exp 1010", rsp_data); end
    tests++; if (sel !== 2'b00) begin fails++; $display("FAIL zero_resp_sel got %b exp 00", sel); end
    tick;
    send(2'b00, 4'b1111, 3'd5);
    tests++; if (sel !== 2'b00) begin fails++; $display("FAIL read_sel got %b exp 00", sel); end
    tick;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL read_rsp_valid got %b exp 1", rsp_valid); end
    tests++; if (rsp_data !== 4'b1010) begin fails++; $display("FAIL read_rsp_data got %b exp 1010", rsp_data); end
    tests++; if (pin !== 4'b1010) begin fails++; $display("FAIL read_pin got %b exp 1010", pin); end
    tick;
  endtask

  task automatic test_shift_right;
    send(2'b01, 4'b0000, 3'd3);
    for (int i = 1; i <= 3; i++) begin
      tests++; if (sel !== 2'b01) begin fails++; $display("FAIL shr_sel_T%0d got %b exp 01", i, sel); end
      tick;
    end
    tests++; if (sel !== 2'b00) begin fails++; $display("FAIL shr_capt_sel got %b exp 00", sel); end
    tests++; if (pout !== 4'b0001) begin fails++; $display("FAIL shr_pout got %b exp 0001", pout); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL shr_early_valid got %b exp 0", rsp_valid); end
    tick;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL shr_rsp_valid got %b exp 1", rsp_valid); end
    tests++; if (rsp_data !== 4'b0001) begin fails++; $display("FAIL shr_rsp_data got %b exp 0001", rsp_data); end
    tick;
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    send(2'b00, 4'b0000, 3'd0);
    tick;
    for (int i = 0; i < 4; i++) begin
      tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid_%0d got %b exp 1", i, rsp_valid); end
      tests++; if (rsp_data !== 4'b0001) begin fails++; $display("FAIL bp_data_%0d got %b exp 0001", i, rsp_data); end
      tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_%0d got %b exp 0", i, cmd_ready); end
      if (i == 1) begin
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 4'b1111; cmd_cnt = 3'd0;
      end
      tick;
      cmd_valid = 1'b0;
    end
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_still_valid got %b exp 1", rsp_valid); end
    rsp_ready = 1'b1;
    tick;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL bp_idle_ready got %b exp 1", cmd_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_idle_busy got %b exp 0", busy); end
    tests++; if (pin !== 4'b1010) begin fails++; $display("FAIL bp_pin got %b exp 1010", pin); end
    tests++; if (pout !== 4'b0001) begin fails++; $display("FAIL bp_pout got %b exp 0001", pout); end
  endtask

  task automatic test_reset_mid_shift;
    logic seen;
    send(2'b10, 4'b0000, 3'd7);
    tests++; if (sel !== 2'b10) begin fails++; $display("FAIL rms_sel1 got %b exp 10", sel); end
    tick;
    tests++; if (sel !== 2'b10) begin fails++; $display("FAIL rms_sel2 got %b exp 10", sel); end
    rst = 1'b0;
    tick;
    rst = 1'b1;
    tests++; if (sel !== 2'b00) begin fails++; $display("FAIL rms_sel got %b exp 00", sel); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rms_busy got %b exp 0", busy); end
    tests++; if (pin !== 4'b0000) begin fails++; $display("FAIL rms_pin got %b exp 0000", pin); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b0) seen = 1'b1;
      tick;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rms_no_rsp got %b exp 0", seen); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rms_ready got %b exp 1", cmd_ready); end
    send(2'b00, 4'b0000, 3'd0);
    tick;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL rms_read_valid got %b exp 1", rsp_valid); end
    tests++; if (rsp_data !== 4'b0100) begin fails++; $display("FAIL rms_read_data got %b exp 0100", rsp_data); end
    tick;
  endtask

  task automatic test_max_count;
    int n;
    int k;
    send(2'b11, 4'b1111, 3'd0);
    tick; tick; tick;
    send(2'b01, 4'b0000, 3'd7);
    n = 0;
    k = 1;
    while (rsp_valid !== 1'b1 && k < 30) begin
      if (sel === 2'b01) n++;
      tick;
      k++;
    end
    tests++; if (n !== 7) begin fails++; $display("FAIL max_shift_cycles got %0d exp 7", n); end
    tests++; if (k !== 9) begin fails++; $display("FAIL max_latency got T+%0d exp T+9", k); end
    tests++; if (rsp_data !== 4'b0000) begin fails++; $display("FAIL max_rsp_data got %b exp 0000", rsp_data); end
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 4'b0000;
    cmd_cnt   = 3'd0;
    rsp_ready = 1'b1;
    test_reset;
    test_load;
    test_zero_and_read;
    test_shift_right;
    test_backpressure;
    test_reset_mid_shift;
    test_max_count;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sft_reg_seq.md
SFT_REG_SEQ -- requirements
Module: sft_reg_seq

Interface
REQ-001 SHALL have parameter W, default 4: data width of the controlled universal shift register.
REQ-002 SHALL have parameter CW, default 3: shift-count width (max count 2^CW-1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-007 SHALL have port cmd_op  input  2  00 READ, 01 shift right, 10 shift left, 11 LOAD.
REQ-008 SHALL have port cmd_data  input  W  parallel-load value (LOAD only).
REQ-009 SHALL have port cmd_cnt  input  CW  shift count (shift ops only).
REQ-010 SHALL have port sel  output  2  register mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-011 SHALL have port pin  output  W  register parallel input.
REQ-012 SHALL have port pout  input  W  register parallel output.
REQ-013 SHALL have port rsp_valid  output  1  result available.
REQ-014 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-015 SHALL have port rsp_data  output  W  register contents at end of command.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, LOAD, SHIFT, CAPT and RESP; sel and pin are Moore outputs of state and internal registers.
REQ-018 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on a cycle with cmd_valid=1 and cmd_ready=1.
REQ-019 SHALL, on acceptance, latch cmd_op, cmd_cnt into the internal counter, and (LOAD only) cmd_data into the pin register; pin is unchanged by non-LOAD commands.
REQ-020 SHALL transition on acceptance: LOAD op -> LOAD; shift op with cnt>0 -> SHIFT; shift op with cnt=0 or READ -> CAPT.
REQ-021 SHALL, in LOAD, drive sel=11 for exactly one cycle, then go to CAPT.
REQ-022 SHALL, in SHIFT, drive sel=01 (right) or 10 (left) for exactly cnt cycles, decrementing the counter each cycle, and go to CAPT after the cycle in which the counter reaches 1.
REQ-023 SHALL drive sel=00 in IDLE, CAPT and RESP.
REQ-024 SHALL, in CAPT, register pout into rsp_data at the end of the cycle, then go to RESP.
REQ-025 SHALL hold rsp_valid=1 and a stable rsp_data in RESP until a cycle with rsp_ready=1, then go to IDLE; cmd_ready becomes 1 on the following cycle.
REQ-026 SHALL give, with acceptance in cycle T, first rsp_valid cycle: READ T+2; LOAD T+3; shift with cnt=N, N>0: T+N+2; shift with cnt=0: T+2.
REQ-027 SHALL ignore cmd_* while not in IDLE; commands are never queued.
REQ-028 SHALL count within CW bits with no wrap: cnt=2^CW-1 yields exactly 2^CW-1 shift cycles.

Reset
REQ-029 SHALL, on a cycle with rst=0, go to IDLE and set sel=00, pin=0, rsp_data=0, rsp_valid=0, busy=0, counter=0, cmd_ready=1 from the next cycle.
REQ-030 SHALL let reset override any state including mid-SHIFT and RESP; the aborted command produces no response.
REQ-031 SHALL leave register contents uncontrolled during reset other than sel=00 (hold) after the reset edge.

Verification
REQ-032 SHALL pass: rst=0 for 2 cycles -> sel=00, pin=0000, rsp_valid=0, busy=0, cmd_ready=1.
REQ-033 SHALL pass: LOAD 1010 accepted at T -> sel=11, pin=1010 in T+1; rsp_valid at T+3 with rsp_data=1010.
REQ-034 SHALL pass: after LOAD 1010, shift right cnt=3 at T -> sel=01 in exactly T+1..T+3, sel=00 at T+4; rsp_valid at T+5 with rsp_data equal to pout sampled in T+4.
REQ-035 SHALL pass: shift left cnt=0 and READ -> sel never leaves 00; rsp_valid at T+2 with rsp_data=1010.
REQ-036 SHALL pass: rsp_ready held low 4 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, a second cmd_valid ignored; rsp_ready=1 -> IDLE next cycle.
REQ-037 SHALL pass: rst=0 during the second SHIFT cycle of cnt=7 -> sel=00 and busy=0 after that edge, no rsp_valid, the next command is accepted normally.
